imm_gen_pipe: RTL and testbench

Parametrised, pipelined immediate generator for the decode stage. Covers every RV32I/RV64I immediate format (I, shift-I, S, B, U, J), flags illegal opcodes and precomputes PC-relative targets. Sits between fetch and the register-read/execute stage, behind a valid/ready handshake with a 2-entry skid buffer so decode stalls never drop instructions.

---
 rtl/imm_gen_pipe.sv | 227 ++++++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator with a 2-entry skid buffer.
// Decodes the immediate format from the opcode, sign/zero-extends the
// immediate to XLEN, precomputes in_pc + imm and presents the result
// behind a valid/ready handshake whose in_ready is purely registered.
//
//   state | meaning
//   ------+-----------------------------------------------------
//   EMPTY | neither main nor skid holds an entry
//   ONE   | main holds the entry on the outputs, skid empty
//   FULL  | main and skid both hold entries, upstream stalled
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_REL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_target
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_R       = 3'd0;
    localparam logic [2:0] FMT_I       = 3'd1;
    localparam logic [2:0] FMT_S       = 3'd2;
    localparam logic [2:0] FMT_B       = 3'd3;
    localparam logic [2:0] FMT_U       = 3'd4;
    localparam logic [2:0] FMT_J       = 3'd5;
    localparam logic [2:0] FMT_SHIFT   = 3'd6;
    localparam logic [2:0] FMT_ILLEGAL = 3'd7;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_FENCE    = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM32    = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_REG32    = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, state_nxt;
    entry_t dec, main_q, skid_q;
    logic   accept, pop;
    logic   main_load_in, main_load_skid, skid_load;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               is_shift;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign opcode   = in_instr[6:0];
    assign funct3   = in_instr[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign imm_i    = in_instr[31:20];
    assign imm_s    = {in_instr[31:25], in_instr[11:7]};
    assign imm_b    = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_u    = {in_instr[31:12], 12'b0};
    assign imm_j    = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    // Combinational format decode and immediate extension of the offered instruction.
    always_comb begin
        dec.imm = '0;
        dec.fmt = FMT_ILLEGAL;
        case (opcode)
            OP_IMM: begin
                if (is_shift) begin
                    dec.fmt = FMT_SHIFT;
                    dec.imm = RV64 ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'(imm_i);
                end
            end
            OP_IMM32: begin
                // Word ops only exist on RV64; the shift amount is always 5 bits.
                if (RV64) begin
                    if (is_shift) begin
                        dec.fmt = FMT_SHIFT;
                        dec.imm = XLEN'(in_instr[24:20]);
                    end else begin
                        dec.fmt = FMT_I;
                        dec.imm = XLEN'(imm_i);
                    end
                end
            end
            OP_LOAD, OP_JALR, OP_FENCE: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'(imm_i);
            end
            OP_STORE: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'(imm_s);
            end
            OP_BRANCH: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'(imm_b);
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'(imm_u);
            end
            OP_JAL: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'(imm_j);
            end
            OP_REG, OP_SYSTEM: begin
                dec.fmt = FMT_R;
            end
            OP_REG32: begin
                if (RV64) begin
                    dec.fmt = FMT_R;
                end
            end
            default: begin
                dec.fmt = FMT_ILLEGAL;
            end
        endcase
        // Illegal and R formats carry imm = 0, so their target is simply in_pc.
        dec.target = (PC_REL != 0) ? (in_pc + dec.imm) : '0;
    end

    assign in_ready = (state != FULL);
    assign out_valid = (state != EMPTY);
    assign accept = in_valid && in_ready;
    assign pop = out_valid && out_ready;

    // State register for the main/skid occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and data-movement controls; flush wins over accept and pop.
    always_comb begin
        state_nxt      = state;
        main_load_in   = 1'b0;
        main_load_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = ONE;
                        main_load_in = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_load_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = FULL;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt      = ONE;
                        main_load_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Data registers change only on a load so idle outputs hold their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_load_in) begin
                main_q <= dec;
            end else if (main_load_skid) begin
                main_q <= skid_q;
            end
            if (skid_load) begin
                skid_q <= dec;
            end
        end
    end

    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_illegal = (main_q.fmt == FMT_ILLEGAL);

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an XLEN=32 instance driven through a scoreboard
// and an XLEN=64 instance checked against fixed vectors.
module tb_imm_gen_pipe;

    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] target;
    } exp_t;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tgt;
    } vec32_t;

    typedef struct {
        logic [31:0] ins;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [63:0] tgt;
    } vec64_t;

    logic        clk, rst_n, flush;
    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_imm, out_target;
    logic [2:0]  out_fmt;

    logic        in_valid64, in_ready64, out_valid64, out_ready64, out_illegal64;
    logic [31:0] in_instr64;
    logic [63:0] in_pc64, out_imm64, out_target64;
    logic [2:0]  out_fmt64;

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    imm_gen_pipe #(.XLEN(32), .PC_REL(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_target(out_target)
    );

    imm_gen_pipe #(.XLEN(64), .PC_REL(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid64), .in_ready(in_ready64), .in_instr(in_instr64), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready64), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_illegal64), .out_target(out_target64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference for XLEN=32, written with arithmetic shifts rather than replication.
    function automatic exp_t model32(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [2:0] f3;
        f3 = ins[14:12];
        e.imm = 32'd0;
        e.fmt = 3'd7;
        case (ins[6:0])
            7'h13: begin
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.fmt = 3'd6;
                    e.imm = {27'd0, ins[24:20]};
                end else begin
                    e.fmt = 3'd1;
                    e.imm = $signed(ins) >>> 20;
                end
            end
            7'h03, 7'h67, 7'h0F: begin e.fmt = 3'd1; e.imm = $signed(ins) >>> 20; end
            7'h23: begin e.fmt = 3'd2; e.imm = $signed({ins[31:25], ins[11:7], 20'd0}) >>> 20; end
            7'h63: begin e.fmt = 3'd3; e.imm = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'd0}) >>> 19; end
            7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = {ins[31:12], 12'd0}; end
            7'h6F: begin e.fmt = 3'd5; e.imm = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'd0}) >>> 11; end
            7'h33, 7'h73: begin e.fmt = 3'd0; end
            default: begin e.fmt = 3'd7; end
        endcase
        e.target = pc + e.imm;
        return e;
    endfunction

    function automatic logic [6:0] rand_op();
        case ($urandom_range(0, 14))
            0: return 7'h13;   1: return 7'h03;   2: return 7'h67;
            3: return 7'h0F;   4: return 7'h1B;   5: return 7'h23;
            6: return 7'h63;   7: return 7'h37;   8: return 7'h17;
            9: return 7'h6F;  10: return 7'h33;  11: return 7'h3B;
           12: return 7'h73;  13: return 7'h7F;
            default: return 7'($urandom());
        endcase
    endfunction

    // One clock: record an accepted instruction in the scoreboard, then advance.
    task automatic cyc(input exp_t e, output bit acc);
        acc = in_valid && in_ready && !flush && rst_n;
        if (acc) sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'd0 || out_fmt !== 3'd0 ||
            out_illegal !== 1'b0 || out_target !== 32'd0)
            $display("FAIL reset_state: got v=%b rdy=%b imm=%h fmt=%0d ill=%b tgt=%h want 0 1 0 0 0 0",
                     out_valid, in_ready, out_imm, out_fmt, out_illegal, out_target);
        else n_pass++;
        n_total++;
        if (out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || out_imm64 !== 64'd0 || out_target64 !== 64'd0)
            $display("FAIL reset_state64: got v=%b rdy=%b imm=%h tgt=%h", out_valid64, in_ready64, out_imm64, out_target64);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL reset_idle: got v=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_addi_latency();
        bit acc;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_instr = 32'hFFF00093;
        in_pc = 32'h100;
        cyc(model32(in_instr, in_pc), acc);
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fmt !== 3'd1 || out_target !== 32'hFF)
            $display("FAIL addi_latency: got v=%b imm=%h fmt=%0d tgt=%h want 1 ffffffff 1 000000ff",
                     out_valid, out_imm, out_fmt, out_target);
        else n_pass++;
        void'(sb.pop_front());
        cyc('0, acc);
        n_total++;
        if (out_valid !== 1'b0)
            $display("FAIL addi_drain: got v=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_formats();
        vec32_t v[13];
        exp_t e;
        bit acc;
        v[0]  = '{32'hFFF00093, 32'h100, 32'hFFFFFFFF, 3'd1, 32'h000000FF};
        v[1]  = '{32'hFE112E23, 32'h100, 32'hFFFFFFFC, 3'd2, 32'h000000FC};
        v[2]  = '{32'hFE000CE3, 32'h100, 32'hFFFFFFF8, 3'd3, 32'h000000F8};
        v[3]  = '{32'h123450B7, 32'h100, 32'h12345000, 3'd4, 32'h12345100};
        v[4]  = '{32'h40515093, 32'h100, 32'h00000005, 3'd6, 32'h00000105};
        v[5]  = '{32'h0000007F, 32'h200, 32'h00000000, 3'd7, 32'h00000200};
        v[6]  = '{32'h0000001B, 32'h300, 32'h00000000, 3'd7, 32'h00000300};
        v[7]  = '{32'h0080006F, 32'h100, 32'h00000008, 3'd5, 32'h00000108};
        v[8]  = '{32'h002081B3, 32'h100, 32'h00000000, 3'd0, 32'h00000100};
        v[9]  = '{32'hFFFFF117, 32'h100, 32'hFFFFF000, 3'd4, 32'hFFFFF100};
        v[10] = '{32'h00412083, 32'h100, 32'h00000004, 3'd1, 32'h00000104};
        v[11] = '{32'h02009093, 32'h40,  32'h00000000, 3'd6, 32'h00000040};
        v[12] = '{32'h0000003B, 32'h80,  32'h00000000, 3'd7, 32'h00000080};
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            in_valid = 1'b1;
            in_instr = v[i].ins;
            in_pc = v[i].pc;
            if (out_valid && out_ready) begin
                n_total++;
                e = sb.pop_front();
                if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.target || out_illegal !== (e.fmt == 3'd7))
                    $display("FAIL fmt_out: got imm=%h fmt=%0d tgt=%h ill=%b want imm=%h fmt=%0d tgt=%h",
                             out_imm, out_fmt, out_target, out_illegal, e.imm, e.fmt, e.target);
                else n_pass++;
            end
            cyc('{v[i].imm, v[i].fmt, v[i].tgt}, acc);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                n_total++;
                e = sb.pop_front();
                if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.target || out_illegal !== (e.fmt == 3'd7))
                    $display("FAIL fmt_out: got imm=%h fmt=%0d tgt=%h ill=%b want imm=%h fmt=%0d tgt=%h",
                             out_imm, out_fmt, out_target, out_illegal, e.imm, e.fmt, e.target);
                else n_pass++;
            end
            cyc('0, acc);
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL fmt_timeout: %0d entries never appeared, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_instr = 32'h00100093;
        in_pc = 32'h0;
        cyc(model32(in_instr, in_pc), acc);
        in_instr = 32'h00200093;
        cyc(model32(in_instr, in_pc), acc);
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_imm !== 32'd1)
            $display("FAIL bp_full: got rdy=%b v=%b imm=%h want 0 1 00000001", in_ready, out_valid, out_imm);
        else n_pass++;
        in_instr = 32'h00300093;
        cyc(model32(in_instr, in_pc), acc);
        n_total++;
        if (acc || in_ready !== 1'b0 || out_imm !== 32'd1 || out_fmt !== 3'd1)
            $display("FAIL bp_hold: got acc=%b rdy=%b imm=%h fmt=%0d want 0 0 00000001 1", acc, in_ready, out_imm, out_fmt);
        else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_total++;
            if (out_valid !== 1'b1 || out_imm !== 32'(k + 1))
                $display("FAIL bp_order: slot %0d got v=%b imm=%h want 1 %h", k, out_valid, out_imm, 32'(k + 1));
            else n_pass++;
            if (sb.size() > 0) void'(sb.pop_front());
            cyc(model32(in_instr, in_pc), acc);
            if (acc) in_valid = 1'b0;
        end
        n_total++;
        if (out_valid !== 1'b0 || sb.size() != 0)
            $display("FAIL bp_empty: got v=%b pending=%0d want 0 0", out_valid, sb.size());
        else n_pass++;
        sb.delete();
        in_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t e;
        bit acc;
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_instr = $urandom();
            in_instr[6:0] = rand_op();
            in_pc = $urandom();
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                n_total++;
                if (sb.size() == 0) $display("FAIL rand_out: unexpected entry imm=%h, want none", out_imm);
                else begin
                    e = sb.pop_front();
                    if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.target || out_illegal !== (e.fmt == 3'd7))
                        $display("FAIL rand_out: got imm=%h fmt=%0d tgt=%h ill=%b want imm=%h fmt=%0d tgt=%h",
                                 out_imm, out_fmt, out_target, out_illegal, e.imm, e.fmt, e.target);
                    else n_pass++;
                end
            end
            cyc(model32(in_instr, in_pc), acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                n_total++;
                e = sb.pop_front();
                if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.target)
                    $display("FAIL rand_drain: got imm=%h fmt=%0d tgt=%h want imm=%h fmt=%0d tgt=%h",
                             out_imm, out_fmt, out_target, e.imm, e.fmt, e.target);
                else n_pass++;
            end
            cyc('0, acc);
        end
        n_total++;
        if (sb.size() != 0 || out_valid !== 1'b0)
            $display("FAIL rand_timeout: pending=%0d v=%b want 0 0", sb.size(), out_valid);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_flush();
        exp_t e;
        bit acc;
        int seen;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h0;
        in_instr = 32'h00500093;
        cyc(model32(in_instr, in_pc), acc);
        in_instr = 32'h00600093;
        cyc(model32(in_instr, in_pc), acc);
        in_instr = 32'h07700093;
        flush = 1'b1;
        cyc(model32(in_instr, in_pc), acc);
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL flush_state: got v=%b rdy=%b want 0 1", out_valid, in_ready);
        else n_pass++;
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen++;
            cyc('0, acc);
        end
        n_total++;
        if (seen !== 0)
            $display("FAIL flush_discard: got %0d valid cycles after flush want 0", seen);
        else n_pass++;
        in_valid = 1'b1;
        in_instr = 32'h00900093;
        cyc(model32(in_instr, in_pc), acc);
        in_valid = 1'b0;
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            if (out_valid && out_ready) begin
                n_total++;
                e = sb.pop_front();
                if (out_imm !== e.imm || out_fmt !== e.fmt || out_target !== e.target)
                    $display("FAIL flush_recover: got imm=%h fmt=%0d want imm=%h fmt=%0d", out_imm, out_fmt, e.imm, e.fmt);
                else n_pass++;
            end
            cyc('0, acc);
        end
        if (sb.size() != 0) begin
            n_total++;
            $display("FAIL flush_timeout: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_pc = 32'h400;
        in_instr = 32'hFE112E23;
        cyc(model32(in_instr, in_pc), acc);
        in_instr = 32'h123450B7;
        cyc(model32(in_instr, in_pc), acc);
        in_valid = 1'b0;
        n_total++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL arst_pre: got v=%b rdy=%b want 1 0", out_valid, in_ready);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_imm !== 32'd0 || out_fmt !== 3'd0 || out_target !== 32'd0)
            $display("FAIL arst_immediate: got v=%b rdy=%b imm=%h fmt=%0d tgt=%h want 0 1 0 0 0",
                     out_valid, in_ready, out_imm, out_fmt, out_target);
        else n_pass++;
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        cyc('0, acc);
        n_total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL arst_after: got v=%b rdy=%b want 0 1 (no stale entries)", out_valid, in_ready);
        else n_pass++;
    endtask

    task automatic test_xlen64();
        vec64_t v[6];
        v[0] = '{32'h800000B7, 64'h1000, 64'hFFFFFFFF80000000, 3'd4, 64'hFFFFFFFF80001000};
        v[1] = '{32'h03F01093, 64'h1000, 64'd63,               3'd6, 64'h103F};
        v[2] = '{32'h03F0909B, 64'h1000, 64'd31,               3'd6, 64'h101F};
        v[3] = '{32'hFFF0809B, 64'h1000, 64'hFFFFFFFFFFFFFFFF, 3'd1, 64'h0FFF};
        v[4] = '{32'h0000003B, 64'h1000, 64'd0,                3'd0, 64'h1000};
        v[5] = '{32'hFE000CE3, 64'h1000, 64'hFFFFFFFFFFFFFFF8, 3'd3, 64'h0FF8};
        out_ready64 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid64 = 1'b1;
            in_instr64 = v[i].ins;
            in_pc64 = v[i].pc;
            @(posedge clk);
            #1;
            in_valid64 = 1'b0;
            n_total++;
            if (out_valid64 !== 1'b1 || out_imm64 !== v[i].imm || out_fmt64 !== v[i].fmt ||
                out_target64 !== v[i].tgt || out_illegal64 !== 1'b0)
                $display("FAIL x64_vec%0d: got v=%b imm=%h fmt=%0d tgt=%h want 1 %h %0d %h",
                         i, out_valid64, out_imm64, out_fmt64, out_target64, v[i].imm, v[i].fmt, v[i].tgt);
            else n_pass++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        in_pc = '0;
        out_ready = 1'b0;
        in_valid64 = 1'b0;
        in_instr64 = '0;
        in_pc64 = '0;
        out_ready64 = 1'b0;
        test_reset();
        test_addi_latency();
        test_formats();
        test_backpressure();
        test_random();
        test_flush();
        test_xlen64();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
